// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues a req/ack read for the pc-supplied address,
// holds the returned word for decode and exposes the jump/branch fields
// that the pc block consumes.
module inst_fetch #(
  parameter int unsigned TIMEOUT     = 15,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_fetch_start,
  input  logic [31:0] i_pc_addr,
  input  logic        i_flush,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] o_instr,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [25:0] o_ins_addr,
  output logic [31:0] o_sign_im,
  output logic        o_busy,
  output logic        o_fetch_err
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StHold = 2'd2
  } state_e;

  // Counter value seen on the last allowed REQ cycle.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e      r_state;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic [31:0] r_instr;
  logic        r_instr_valid;
  logic        r_fetch_err;
  logic [7:0]  r_cnt;

  state_e      w_state_d;
  logic        w_mem_req_d;
  logic [31:0] w_mem_addr_d;
  logic [31:0] w_instr_d;
  logic        w_instr_valid_d;
  logic        w_fetch_err_d;
  logic [7:0]  w_cnt_d;
  logic        w_aligned;

  // Next-state and next-register logic; flush outranks every other input.
  always_comb begin
    w_state_d       = r_state;
    w_mem_req_d     = r_mem_req;
    w_mem_addr_d    = r_mem_addr;
    w_instr_d       = r_instr;
    w_instr_valid_d = r_instr_valid;
    w_fetch_err_d   = 1'b0;
    w_cnt_d         = r_cnt;
    w_aligned       = (i_pc_addr[1:0] == 2'b00);

    if (i_flush) begin
      // Abandons any outstanding request or held word; a same-cycle ack is dropped.
      w_state_d       = StIdle;
      w_mem_req_d     = 1'b0;
      w_instr_valid_d = 1'b0;
      w_instr_d       = RESET_INSTR;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_fetch_start) begin
            if (w_aligned) begin
              w_state_d    = StReq;
              w_mem_req_d  = 1'b1;
              w_mem_addr_d = i_pc_addr;
              w_cnt_d      = 8'd0;
            end else begin
              w_fetch_err_d = 1'b1;
            end
          end
        end
        StReq: begin
          if (i_mem_ack) begin
            // An ack on the final allowed cycle still wins over the timeout.
            w_state_d       = StHold;
            w_mem_req_d     = 1'b0;
            w_instr_d       = i_mem_rdata;
            w_instr_valid_d = 1'b1;
          end else if (r_cnt == TimeoutLast) begin
            w_state_d     = StIdle;
            w_mem_req_d   = 1'b0;
            w_fetch_err_d = 1'b1;
          end else begin
            w_cnt_d = r_cnt + 8'd1;
          end
        end
        StHold: begin
          if (i_instr_ready) begin
            w_instr_valid_d = 1'b0;
            w_instr_d       = RESET_INSTR;
            w_state_d       = StIdle;
            if (i_fetch_start) begin
              if (w_aligned) begin
                // Back-to-back fetch without an idle bubble.
                w_state_d    = StReq;
                w_mem_req_d  = 1'b1;
                w_mem_addr_d = i_pc_addr;
                w_cnt_d      = 8'd0;
              end else begin
                w_fetch_err_d = 1'b1;
              end
            end
          end
        end
        default: begin
          w_state_d       = StIdle;
          w_mem_req_d     = 1'b0;
          w_instr_valid_d = 1'b0;
          w_instr_d       = RESET_INSTR;
        end
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= StIdle;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= 32'd0;
      r_instr       <= RESET_INSTR;
      r_instr_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_cnt         <= 8'd0;
    end else begin
      r_state       <= w_state_d;
      r_mem_req     <= w_mem_req_d;
      r_mem_addr    <= w_mem_addr_d;
      r_instr       <= w_instr_d;
      r_instr_valid <= w_instr_valid_d;
      r_fetch_err   <= w_fetch_err_d;
      r_cnt         <= w_cnt_d;
    end
  end

  assign o_mem_req     = r_mem_req;
  assign o_mem_addr    = r_mem_addr;
  assign o_instr       = r_instr;
  assign o_instr_valid = r_instr_valid;
  assign o_fetch_err   = r_fetch_err;
  assign o_busy        = (r_state == StReq);
  assign o_ins_addr    = r_instr[25:0];
  assign o_sign_im     = {{16{r_instr[15]}}, r_instr[15:0]};

endmodule
